// File: rtl/i2c_ctrl_pkg.sv
// rtl/i2c_ctrl_pkg.sv - shared types and constants for the I2C command controller
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  localparam int QUARTERS_PER_BYTE = 36;
  localparam int QUARTERS_FULL     = 116;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-bit period divider; tick marks the last clk of each quarter
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_cmd_ctrl.sv
// rtl/i2c_cmd_ctrl.sv - Avalon-MM slave running START, three ACK-checked bytes and STOP on I2C
module i2c_cmd_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  state_t      state, state_n;
  logic [1:0]  quarter, quarter_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_cnt, byte_n;
  logic [7:0]  shift, shift_n;
  logic [23:0] cmd;
  logic        nack;
  logic        ack_bad;
  logic        busy;
  logic        tick;
  logic        sda_meta, sda_sync;
  logic        scl_d, sda_low_d;
  logic        scl_q, sda_low_q;
  logic        cmd_accept, status_write, ack_sample;
  logic        unused_bits;

  assign unused_bits  = ^writedata[31:24];
  assign busy         = (state != ST_IDLE);
  assign cmd_accept   = chipselect && !write_n && (address == ADDR_CMD) && !busy;
  assign status_write = chipselect && !write_n && (address == ADDR_STATUS);
  assign ack_sample   = (state == ST_ACK) && (quarter == 2'd2) && tick;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .clear  (!busy),
    .tick   (tick)
  );

  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    shift_n   = shift;
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    if (tick) begin
      quarter_n = quarter + 2'd1;
    end
    case (state)
      ST_IDLE: begin
        quarter_n = 2'd0;
        if (cmd_accept) begin
          state_n = ST_START;
          byte_n  = 2'd0;
          bit_n   = 3'd7;
          shift_n = writedata[23:16];
        end
      end
      ST_START: begin
        scl_d     = (quarter != 2'd3);
        sda_low_d = (quarter != 2'd0);
        if (tick && quarter == 2'd3) begin
          state_n = ST_BIT;
          bit_n   = 3'd7;
        end
      end
      ST_BIT: begin
        scl_d     = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low_d = !shift[7];
        if (tick && quarter == 2'd3) begin
          shift_n = {shift[6:0], 1'b0};
          if (bit_cnt == 3'd0) begin
            state_n = ST_ACK;
          end else begin
            bit_n = bit_cnt - 3'd1;
          end
        end
      end
      ST_ACK: begin
        scl_d = (quarter == 2'd1) || (quarter == 2'd2);
        // The slave's answer was captured at the end of q2; act on it once the slot closes.
        if (tick && quarter == 2'd3) begin
          if (ack_bad || byte_cnt == 2'd2) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_BIT;
            byte_n  = byte_cnt + 2'd1;
            bit_n   = 3'd7;
            shift_n = (byte_cnt == 2'd0) ? cmd[15:8] : cmd[7:0];
          end
        end
      end
      ST_STOP: begin
        scl_d     = (quarter != 2'd0);
        sda_low_d = (quarter == 2'd0) || (quarter == 2'd1);
        if (tick && quarter == 2'd3) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      shift     <= 8'd0;
      cmd       <= 24'd0;
      nack      <= 1'b0;
      ack_bad   <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      readdata  <= 32'd0;
    end else begin
      state     <= state_n;
      quarter   <= quarter_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      shift     <= shift_n;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      sda_meta  <= i2c_sdat;
      sda_sync  <= sda_meta;
      if (cmd_accept) begin
        cmd <= writedata[23:0];
      end
      if (ack_sample) begin
        ack_bad <= sda_sync;
      end
      if (ack_sample && sda_sync) begin
        nack <= 1'b1;
      end else if (cmd_accept || (status_write && writedata[1])) begin
        nack <= 1'b0;
      end
      case (address)
        ADDR_CMD:    readdata <= {8'h00, cmd};
        ADDR_STATUS: readdata <= {30'd0, nack, busy};
        default:     readdata <= 32'd0;
      endcase
    end
  end

  assign i2c_sclk = scl_q;
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
// tb/tb_i2c_cmd_ctrl.sv - scoreboard bench for i2c_cmd_ctrl with an I2C slave model
module tb_i2c_cmd_ctrl;
  import i2c_ctrl_pkg::*;

  localparam int CLK_DIV = 4;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        i2c_sclk;
  wire         sda_bus;
  logic        slave_low;

  int checks;
  int failures;
  bit mon_en;
  int slave_nack_byte;
  logic [1:0] rd_addr;

  logic [7:0] exp_bytes[$];
  int         exp_busy[$];
  bit         exp_nack[$];

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_cmd_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .i2c_sclk   (i2c_sclk),
    .i2c_sdat   (sda_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rd_addr <= address;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [23:0] c, input int idx);
    logic [23:0] t;
    t = c >> (16 - 8 * idx);
    return t[7:0];
  endfunction

  // Bus decoder plus slave: decodes START/STOP/bits, answers each ACK slot.
  initial begin : bus_mon
    logic ps, pd, scl_s, sda_s, in_frame;
    int bitcnt, byte_idx;
    logic [7:0] sh;
    ps = 1'b1; pd = 1'b1; in_frame = 1'b0; bitcnt = 0; byte_idx = 0; sh = 8'd0;
    slave_low = 1'b0;
    forever begin
      @(negedge clk);
      scl_s = i2c_sclk;
      sda_s = (sda_bus !== 1'b0);
      if (reset) begin
        in_frame = 1'b0; bitcnt = 0; slave_low = 1'b0;
      end else if (ps && scl_s && (pd != sda_s)) begin
        if (!sda_s) begin
          if (mon_en) check("start_in_frame", in_frame, 0);
          in_frame = 1'b1; bitcnt = 0; byte_idx = 0; sh = 8'd0;
        end else begin
          if (mon_en) begin
            check("stop_after_start", in_frame, 1);
            check("stop_boundary", {bitcnt[7:0], 7'd0, sh[0]}, {8'd1, 8'd0});
            check("bytes_left", exp_bytes.size(), 0);
          end
          in_frame = 1'b0;
        end
      end else if (!ps && scl_s && in_frame) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda_s};
          bitcnt++;
          if (bitcnt == 8 && mon_en) begin
            if (exp_bytes.size() == 0) check("extra_byte", sh, 8'hxx);
            else check("bus_byte", sh, exp_bytes.pop_front());
          end
        end else begin
          bitcnt = 0;
          byte_idx++;
        end
      end else if (ps && !scl_s && in_frame) begin
        slave_low = (bitcnt == 8) && (byte_idx != slave_nack_byte);
      end
      ps = scl_s;
      pd = sda_s;
    end
  end

  // Busy/nack monitor: measures the busy window seen through the status register.
  bit busy_on;
  initial begin : busy_mon
    int cnt;
    busy_on = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_on = 1'b0; cnt = 0;
      end else if (busy_on) begin
        if (rd_addr == ADDR_STATUS && !readdata[0]) begin
          busy_on = 1'b0;
          if (mon_en) begin
            if (exp_busy.size() == 0) begin
              check("busy_unexpected", cnt, 0);
            end else begin
              check("busy_cycles", cnt, exp_busy.pop_front());
              check("nack_at_done", readdata[1], exp_nack.pop_front());
            end
          end
        end else begin
          cnt++;
        end
      end else if (rd_addr == ADDR_STATUS && readdata[0]) begin
        busy_on = 1'b1; cnt = 1;
      end
    end
  end

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; address = a; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS; writedata = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a;
    @(posedge clk); #1;
    d = readdata;
    address = ADDR_STATUS;
  endtask

  task automatic start_txn(input logic [23:0] c, input int nb, input bit track);
    int n;
    slave_nack_byte = nb;
    if (track) begin
      n = (nb < 3) ? nb : 2;
      for (int i = 0; i <= n; i++) exp_bytes.push_back(byte_of(c, i));
      exp_busy.push_back((QUARTERS_FULL - (2 - n) * QUARTERS_PER_BYTE) * CLK_DIV);
      exp_nack.push_back(nb < 3);
    end
    write_reg(ADDR_CMD, {8'h00, c});
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (exp_busy.size() == 0 && !busy_on) done = 1'b1;
    end
    check(name, done, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [23:0] c;
    int nb;
    checks = 0; failures = 0;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
    writedata = 32'd0; mon_en = 1'b1; slave_nack_byte = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_scl", i2c_sclk, 1'b1);
    check("reset_sda", sda_bus !== 1'b0, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    read_reg(ADDR_CMD, d);
    check("reset_cmd", d, 32'd0);

    start_txn(24'h340A1F, 3, 1'b1);
    wait_done("done_ack_all");
    read_reg(ADDR_CMD, d);
    check("cmd_readback", d, 32'h00340A1F);

    start_txn(24'h340A1F, 1, 1'b1);
    wait_done("done_nack_reg");
    read_reg(ADDR_STATUS, d);
    check("status_nack", d, 32'h2);
    write_reg(ADDR_STATUS, 32'h2);
    read_reg(ADDR_STATUS, d);
    check("status_cleared", d, 32'h0);

    write_reg(2'd2, 32'hFFFFFFFF);
    read_reg(2'd2, d);
    check("addr2_reads_zero", d, 32'h0);
    read_reg(2'd3, d);
    check("addr3_reads_zero", d, 32'h0);

    for (int k = 0; k < 6; k++) begin
      c = 24'($urandom);
      nb = $urandom_range(0, 3);
      start_txn(c, nb, 1'b1);
      wait_done("done_random");
      read_reg(ADDR_STATUS, d);
      check("status_random", d, {30'd0, nb < 3, 1'b0});
    end

    c = 24'h12ABE7;
    start_txn(c, 3, 1'b1);
    repeat (80) @(posedge clk);
    write_reg(ADDR_CMD, 32'h00FFFFFF);
    read_reg(ADDR_CMD, d);
    check("cmd_ignored_busy", d, {8'h00, c});
    wait_done("done_ignored");
    read_reg(ADDR_CMD, d);
    check("cmd_after_ignored", d, {8'h00, c});

    mon_en = 1'b0;
    start_txn(24'h5AC396, 3, 1'b0);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_scl", i2c_sclk, 1'b1);
    check("midreset_sda", sda_bus !== 1'b0, 1'b1);
    check("midreset_readdata", readdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    read_reg(ADDR_STATUS, d);
    check("midreset_busy", d, 32'd0);
    read_reg(ADDR_CMD, d);
    check("midreset_cmd", d, 32'd0);
    repeat (10) @(negedge clk);
    mon_en = 1'b1;
    start_txn(24'h4C2201, 3, 1'b1);
    wait_done("done_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
